// File: rtl/dm_sized.sv
// Byte-addressed little-endian data memory with sized loads/stores,
// a req/ready handshake and a fixed number of wait states per access.
module dm_sized #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic                  ready,
    output logic                  err,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAITS = 4'(LATENCY);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  sext_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           din_q;
    logic                  latch_en;

    logic [31:0] dout_q, dout_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    // Zero-filled at time 0; reset leaves the contents alone.
    logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

    logic [ADDR_WIDTH-1:0] lane_addr [4];
    logic [7:0]            rd_byte   [4];
    logic [3:0]            byte_en;
    logic                  misaligned;
    logic [31:0]           load_val;
    logic                  commit;
    logic                  wr_en;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr_q + ADDR_WIDTH'(k);
            rd_byte[k]   = mem_q[lane_addr[k]];
        end
    end

    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        unique case (size_q)
            2'b00: byte_en = 4'b0001;
            2'b01: begin
                byte_en    = 4'b0011;
                misaligned = addr_q[0];
            end
            2'b10: begin
                byte_en    = 4'b1111;
                misaligned = |addr_q[1:0];
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        load_val = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
        unique case (size_q)
            2'b00: load_val = {{24{sext_q & rd_byte[0][7]}}, rd_byte[0]};
            2'b01: load_val = {{16{sext_q & rd_byte[1][7]}},
                               rd_byte[1], rd_byte[0]};
            default: load_val = {rd_byte[3], rd_byte[2],
                                 rd_byte[1], rd_byte[0]};
        endcase
    end

    assign commit = (state_q == ACCESS) && (cnt_q == 4'd0);
    // A reset on the commit edge discards the store.
    assign wr_en  = commit && we_q && !misaligned && !rst;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        dout_d   = dout_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    latch_en = 1'b1;
                    cnt_d    = WAITS;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    err_d   = misaligned;
                    if (!we_q && !misaligned) begin
                        dout_d = load_val;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (latch_en) begin
                we_q   <= we;
                size_q <= size;
                sext_q <= sext;
                addr_q <= addr;
                din_q  <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem_q[lane_addr[k]] <= din_q[8*k +: 8];
                end
            end
        end
    end

    assign dout  = dout_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q == ACCESS);

endmodule

// File: tb/tb_dm_sized.sv
// Bench for dm_sized: three instances (1, 0 and 3 wait states) checked
// every cycle against a transaction-level model, plus directed literals.
module tb_dm_sized;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst_r, req_r, we_r, sext_r;
    logic [N-1:0][1:0]  size_r;
    logic [N-1:0][11:0] addr_r;
    logic [N-1:0][31:0] din_r;
    logic [N-1:0][31:0] dout_w;
    logic [N-1:0]       ready_w, err_w, busy_w;

    dm_sized #(.ADDR_WIDTH(12), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst_r[0]), .req(req_r[0]), .we(we_r[0]),
        .size(size_r[0]), .sext(sext_r[0]), .addr(addr_r[0]),
        .din(din_r[0]), .dout(dout_w[0]), .ready(ready_w[0]),
        .err(err_w[0]), .busy(busy_w[0])
    );

    dm_sized #(.ADDR_WIDTH(12), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst_r[1]), .req(req_r[1]), .we(we_r[1]),
        .size(size_r[1]), .sext(sext_r[1]), .addr(addr_r[1]),
        .din(din_r[1]), .dout(dout_w[1]), .ready(ready_w[1]),
        .err(err_w[1]), .busy(busy_w[1])
    );

    dm_sized #(.ADDR_WIDTH(12), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst_r[2]), .req(req_r[2]), .we(we_r[2]),
        .size(size_r[2]), .sext(sext_r[2]), .addr(addr_r[2]),
        .din(din_r[2]), .dout(dout_w[2]), .ready(ready_w[2]),
        .err(err_w[2]), .busy(busy_w[2])
    );

    int lat_of [N];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: an accepted access occupies the memory until its completion
    // edge, LATENCY+1 edges after acceptance.
    logic [7:0]  mm [N][4096];
    bit          pend [N];
    bit          armed [N];
    int          t0 [N];
    logic        p_we [N];
    logic [1:0]  p_size [N];
    logic        p_sext [N];
    logic [11:0] p_addr [N];
    logic [31:0] p_din [N];
    logic [31:0] e_dout [N];
    bit          e_ready [N];
    bit          e_err [N];
    bit          e_busy [N];

    function automatic bit illegal(logic [1:0] s, int a);
        return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) ||
               (s == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] mload(int i, logic [1:0] s,
                                          logic sx, int a);
        int v;
        case (s)
            2'd0: begin
                v = int'(mm[i][a]);
                if (sx && v > 127) v = v - 256;
            end
            2'd1: begin
                v = int'(mm[i][a]) + 256 * int'(mm[i][a+1]);
                if (sx && v > 32767) v = v - 65536;
            end
            default: return {mm[i][a+3], mm[i][a+2], mm[i][a+1], mm[i][a]};
        endcase
        return 32'(v);
    endfunction

    task automatic mstore(int i, logic [1:0] s, int a, logic [31:0] d);
        int nb;
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++) mm[i][a+k] = 8'(d >> (8 * k));
    endtask

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc %0d: got %h expected %h",
                     nm, i, cyc, act, exp);
        end
    endtask

    initial begin
        lat_of[0] = 1;
        lat_of[1] = 0;
        lat_of[2] = 3;
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 4096; a++) mm[i][a] = 8'h00;
            pend[i]    = 1'b0;
            armed[i]   = 1'b0;
            e_dout[i]  = 32'd0;
            e_ready[i] = 1'b0;
            e_err[i]   = 1'b0;
            e_busy[i]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                e_ready[i] = 1'b0;
                e_err[i]   = 1'b0;
                if (rst_r[i]) begin
                    pend[i]   = 1'b0;
                    e_dout[i] = 32'd0;
                    armed[i]  = 1'b1;
                end else if (pend[i] && cyc == t0[i] + lat_of[i] + 1) begin
                    pend[i]    = 1'b0;
                    e_ready[i] = 1'b1;
                    if (illegal(p_size[i], int'(p_addr[i]))) begin
                        e_err[i] = 1'b1;
                    end else if (p_we[i]) begin
                        mstore(i, p_size[i], int'(p_addr[i]), p_din[i]);
                    end else begin
                        e_dout[i] = mload(i, p_size[i], p_sext[i],
                                          int'(p_addr[i]));
                    end
                end else if (!pend[i] && req_r[i]) begin
                    pend[i]   = 1'b1;
                    t0[i]     = cyc;
                    p_we[i]   = we_r[i];
                    p_size[i] = size_r[i];
                    p_sext[i] = sext_r[i];
                    p_addr[i] = addr_r[i];
                    p_din[i]  = din_r[i];
                end
                e_busy[i] = pend[i];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (armed[i]) begin
                    chk("busy", i, 32'(busy_w[i]), 32'(e_busy[i]));
                    chk("ready", i, 32'(ready_w[i]), 32'(e_ready[i]));
                    chk("err", i, 32'(err_w[i]), 32'(e_err[i]));
                    chk("dout", i, dout_w[i], e_dout[i]);
                end
            end
        end
    end

    task automatic access(input int i, input logic w, input logic [1:0] s,
                          input logic sx, input logic [11:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] dq, output logic e);
        int ts;
        @(negedge clk);
        req_r[i]  = 1'b1;
        we_r[i]   = w;
        size_r[i] = s;
        sext_r[i] = sx;
        addr_r[i] = a;
        din_r[i]  = d;
        @(negedge clk);
        req_r[i] = 1'b0;
        ts  = cyc;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (ready_w[i]) begin
                lat = cyc - ts;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout inst%0d: got none expected pulse", i);
        end
        dq = dout_w[i];
        e  = err_w[i];
    endtask

    task automatic dchk(string nm, int i, logic w, logic [1:0] s, logic sx,
                        logic [11:0] a, logic [31:0] d,
                        logic [31:0] exp_dout, logic exp_err);
        int lat;
        logic [31:0] dq;
        logic e;
        access(i, w, s, sx, a, d, lat, dq, e);
        chk({nm, "_lat"}, i, 32'(lat), 32'(lat_of[i] + 1));
        chk({nm, "_dout"}, i, dq, exp_dout);
        chk({nm, "_err"}, i, 32'(e), 32'(exp_err));
    endtask

    task automatic rnd_phase(int i, int nops);
        int hold;
        int a;
        logic [1:0] s;
        for (int op = 0; op < nops; op++) begin
            if ($urandom_range(0, 99) < 4) begin
                @(negedge clk);
                rst_r[i] = 1'b1;
                @(negedge clk);
                rst_r[i] = 1'b0;
            end else begin
                s = ($urandom_range(0, 7) == 0) ? 2'd3 :
                    2'($urandom_range(0, 2));
                a = ($urandom_range(0, 3) == 3) ? 4080 + $urandom_range(0, 15)
                                                : $urandom_range(0, 63);
                if ($urandom_range(0, 3) != 0 && s != 2'd3) begin
                    a = a - (a % (1 << s));
                end
                hold = $urandom_range(1, 3);
                @(negedge clk);
                req_r[i]  = 1'b1;
                we_r[i]   = 1'($urandom_range(0, 1));
                size_r[i] = s;
                sext_r[i] = 1'($urandom_range(0, 1));
                addr_r[i] = 12'(a);
                din_r[i]  = $urandom;
                repeat (hold) @(negedge clk);
                req_r[i] = 1'b0;
                repeat ($urandom_range(0, lat_of[i] + 3)) @(negedge clk);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ts;
        int rc;
        rst_r  = '1;
        req_r  = '0;
        we_r   = '0;
        sext_r = '0;
        size_r = '0;
        addr_r = '0;
        din_r  = '0;
        repeat (3) @(negedge clk);
        rst_r = '0;
        @(negedge clk);
        chk("rst_dout", 0, dout_w[0], 32'd0);
        chk("rst_ready", 0, 32'(ready_w[0]), 32'd0);
        chk("rst_err", 0, 32'(err_w[0]), 32'd0);
        chk("rst_busy", 2, 32'(busy_w[2]), 32'd0);

        // Word round trip, sub-word access, misalignment (1 wait state).
        dchk("sw10", 0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'd0, 1'b0);
        dchk("lw10", 0, 1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 32'hDEADBEEF, 1'b0);
        dchk("sb11", 0, 1'b1, 2'd0, 1'b0, 12'h011, 32'h12345680,
             32'hDEADBEEF, 1'b0);
        dchk("lw10b", 0, 1'b0, 2'd2, 1'b1, 12'h010, 32'd0, 32'hDEAD80EF, 1'b0);
        dchk("lb11", 0, 1'b0, 2'd0, 1'b1, 12'h011, 32'd0, 32'hFFFFFF80, 1'b0);
        dchk("lbu11", 0, 1'b0, 2'd0, 1'b0, 12'h011, 32'd0, 32'h00000080, 1'b0);
        dchk("lh12", 0, 1'b0, 2'd1, 1'b1, 12'h012, 32'd0, 32'hFFFFDEAD, 1'b0);
        dchk("lhu12", 0, 1'b0, 2'd1, 1'b0, 12'h012, 32'd0, 32'h0000DEAD, 1'b0);
        dchk("sw13", 0, 1'b1, 2'd2, 1'b0, 12'h013, 32'h11111111,
             32'h0000DEAD, 1'b1);
        dchk("lh11", 0, 1'b0, 2'd1, 1'b1, 12'h011, 32'd0, 32'h0000DEAD, 1'b1);
        dchk("rsv00", 0, 1'b0, 2'd3, 1'b0, 12'h000, 32'd0, 32'h0000DEAD, 1'b1);
        dchk("lw10c", 0, 1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 32'hDEAD80EF, 1'b0);

        // Zero wait states, req held: every other byte store is accepted.
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ready_w[1]) cnt++;
            req_r[1]  = 1'b1;
            we_r[1]   = 1'b1;
            size_r[1] = 2'd0;
            addr_r[1] = 12'h040 + 12'(n);
            din_r[1]  = 32'(n);
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (ready_w[1]) cnt++;
            req_r[1] = 1'b0;
        end
        chk("b2b_pulses", 1, 32'(cnt), 32'd4);
        dchk("lw44", 1, 1'b0, 2'd2, 1'b0, 12'h044, 32'd0, 32'h00060004, 1'b0);
        dchk("lw40", 1, 1'b0, 2'd2, 1'b0, 12'h040, 32'd0, 32'h00020000, 1'b0);

        // Three wait states; a second req pulse while busy is dropped.
        @(negedge clk);
        req_r[2]  = 1'b1;
        we_r[2]   = 1'b1;
        size_r[2] = 2'd2;
        addr_r[2] = 12'h030;
        din_r[2]  = 32'hCAFEF00D;
        @(negedge clk);
        ts = cyc;
        req_r[2] = 1'b0;
        cnt = 0;
        rc  = -1;
        for (int n = 0; n < 10; n++) begin
            if (n == 1) begin
                req_r[2]  = 1'b1;
                addr_r[2] = 12'h034;
                din_r[2]  = 32'h55555555;
            end
            if (n == 2) req_r[2] = 1'b0;
            if (ready_w[2]) begin
                cnt++;
                rc = cyc - ts;
            end
            @(negedge clk);
        end
        chk("l3_pulses", 2, 32'(cnt), 32'd1);
        chk("l3_lat", 2, 32'(rc), 32'd4);
        dchk("lw34", 2, 1'b0, 2'd2, 1'b0, 12'h034, 32'd0, 32'h00000000, 1'b0);
        dchk("lw30", 2, 1'b0, 2'd2, 1'b0, 12'h030, 32'd0, 32'hCAFEF00D, 1'b0);

        // Reset two edges into a three-wait store aborts it.
        @(negedge clk);
        req_r[2]  = 1'b1;
        we_r[2]   = 1'b1;
        size_r[2] = 2'd2;
        addr_r[2] = 12'h020;
        din_r[2]  = 32'h12345678;
        @(negedge clk);
        req_r[2] = 1'b0;
        cnt = 0;
        @(negedge clk);
        rst_r[2] = 1'b1;
        @(negedge clk);
        rst_r[2] = 1'b0;
        chk("ra_busy", 2, 32'(busy_w[2]), 32'd0);
        chk("ra_dout", 2, dout_w[2], 32'd0);
        chk("ra_err", 2, 32'(err_w[2]), 32'd0);
        for (int n = 0; n < 6; n++) begin
            if (ready_w[2]) cnt++;
            @(negedge clk);
        end
        chk("ra_pulses", 2, 32'(cnt), 32'd0);
        dchk("lw20", 2, 1'b0, 2'd2, 1'b0, 12'h020, 32'd0, 32'h00000000, 1'b0);

        for (int i = 0; i < N; i++) rnd_phase(i, 250);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
